// File: rtl/jpeg_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO; the core stores
// bytes to DATA and polls STATUS or waits on irq_empty.
module jpeg_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        bus_write,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        txd,
  output logic        irq_empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bitidx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic accept;
  logic clear_ovf;
  logic [3:0] count_sat;
  logic unused_wdata;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign push      = bus_write && (bus_addr == 3'd0);
  assign clear_ovf = bus_write && (bus_addr == 3'd4) && bus_wdata[3];
  // The shifter takes a byte when idle, or at the last stop-bit cycle so frames chain without a gap.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && (baud == '0)));
  assign accept    = push && (!full || pop);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      // A dropped byte wins over a clear landing in the same cycle.
      if (push && !accept)     overflow <= 1'b1;
      else if (clear_ovf)      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wptr] <= bus_wdata[7:0];
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      baud   <= '0;
      bitidx <= '0;
      shift  <= '0;
      txd    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift <= mem[rptr];
            baud  <= BAUD_LOAD;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud == '0) begin
            baud   <= BAUD_LOAD;
            bitidx <= '0;
            state  <= DATA;
            txd    <= shift[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud  <= BAUD_LOAD;
            shift <= {1'b0, shift[7:1]};
            if (bitidx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bitidx <= bitidx + 1'b1;
              txd    <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            if (pop) begin
              shift <= mem[rptr];
              baud  <= BAUD_LOAD;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  assign count_sat = (count > CW'(15)) ? 4'hF : 4'(count);

  always_comb begin
    bus_rdata = '0;
    if (bus_addr == 3'd4)
      bus_rdata = {24'd0, count_sat, overflow, (state != IDLE), empty, full};
  end

  assign irq_empty    = empty && (state == IDLE);
  assign unused_wdata = ^bus_wdata[31:8];

endmodule

// File: tb/tb_jpeg_uart_tx.sv
// Scoreboard bench for jpeg_uart_tx: written bytes are queued as expectations
// and a negedge-sampling receiver decodes txd frames and compares them.
module tb_jpeg_uart_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME      = 10 * CLK_DIV;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        bus_write = 1'b0;
  logic [2:0]  bus_addr = 3'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        txd;
  logic        irq_empty;

  int assertCount = 0;
  int failCount = 0;
  int cycle = 0;
  int frameCount = 0;
  int rxPhase = 0;
  int rxSlot;
  logic [7:0] rxByte;
  logic rxBit;
  logic frameBad;
  logic [7:0] expQ[$];
  int startLog[$];

  jpeg_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock),
    .nreset(nreset),
    .bus_write(bus_write),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .txd(txd),
    .irq_empty(irq_empty)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Receiver: one step per negedge; every sample of each bit period must agree.
  always @(negedge clock) begin
    if (!nreset) begin
      rxPhase = 0;
    end else if (rxPhase == 0) begin
      if (txd === 1'b0) begin
        rxPhase = 1;
        frameBad = 1'b0;
        startLog.push_back(cycle);
      end
    end else begin
      rxSlot = rxPhase / CLK_DIV;
      if (rxSlot == 0) begin
        if (txd !== 1'b0) frameBad = 1'b1;
      end else if (rxSlot <= 8) begin
        if (rxPhase % CLK_DIV == 0) begin
          rxBit = txd;
          rxByte[rxSlot-1] = txd;
        end else if (txd !== rxBit) begin
          frameBad = 1'b1;
        end
      end else if (txd !== 1'b1) begin
        frameBad = 1'b1;
      end
      rxPhase++;
      if (rxPhase == FRAME) begin
        rxPhase = 0;
        frameCount++;
        checkOutput("framing", 32'(frameBad), 32'd0);
        if (expQ.size() == 0) checkOutput("spurious", {24'd0, rxByte}, 32'hFFFF_FFFF);
        else checkOutput("rxbyte", {24'd0, rxByte}, {24'd0, expQ.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    bus_write = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    @(negedge clock);
    bus_write = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] addr, input logic [31:0] expected);
    bus_addr = addr;
    #1;
    checkOutput(tag, bus_rdata, expected);
  endtask

  task automatic waitFrames(input int target);
    int spent = 0;
    while (frameCount < target && spent < 15 * FRAME) begin
      @(negedge clock);
      spent++;
    end
    checkOutput("frames", 32'(frameCount), 32'(target));
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int target;
    int spent;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_txd", 32'(txd), 32'd1);
    checkOutput("rst_irq", 32'(irq_empty), 32'd1);
    checkReg("rst_status", 3'd4, 32'h2);
    nreset = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("idle_txd", 32'(txd), 32'd1);
    checkOutput("idle_frames", 32'(frameCount), 32'd0);

    // Single frame: latency and exact length
    expQ.push_back(8'hA5);
    applyStimulus(3'd0, 32'hA5);
    checkOutput("lat_hold", 32'(txd), 32'd1);
    checkOutput("lat_irq", 32'(irq_empty), 32'd0);
    @(negedge clock);
    checkOutput("lat_fall", 32'(txd), 32'd0);
    repeat (FRAME - 1) @(negedge clock);
    checkOutput("stop_txd", 32'(txd), 32'd1);
    checkReg("last_stop_status", 3'd4, 32'h6);
    checkOutput("last_stop_irq", 32'(irq_empty), 32'd0);
    @(negedge clock);
    checkReg("after_frame_status", 3'd4, 32'h2);
    checkOutput("after_frame_irq", 32'(irq_empty), 32'd1);
    checkOutput("one_frame", 32'(frameCount), 32'd1);

    // Back-to-back frames
    base = startLog.size();
    target = frameCount + 3;
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h33);
    applyStimulus(3'd0, 32'h11);
    applyStimulus(3'd0, 32'h22);
    applyStimulus(3'd0, 32'h33);
    waitFrames(target);
    checkOutput("gap01", 32'(startLog[base+1] - startLog[base]), 32'(FRAME));
    checkOutput("gap12", 32'(startLog[base+2] - startLog[base+1]), 32'(FRAME));

    // Overflow, clear, and push-with-pop while full
    base = startLog.size();
    target = frameCount + 10;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expQ.push_back(8'(8'h40 + i));
      applyStimulus(3'd0, 32'(32'h40 + i));
    end
    checkReg("full_ovf_status", 3'd4, 32'h8D);
    applyStimulus(3'd4, 32'h8);
    checkReg("ovf_clear_status", 3'd4, 32'h85);
    spent = 0;
    while ((startLog.size() <= base || cycle != startLog[base] + FRAME - 1) && spent < 2 * FRAME) begin
      @(negedge clock);
      spent++;
    end
    checkOutput("pop_align", 32'(spent < 2 * FRAME), 32'd1);
    expQ.push_back(8'h4A);
    applyStimulus(3'd0, 32'h4A);
    checkReg("push_pop_status", 3'd4, 32'h85);
    waitFrames(target);
    checkReg("drained_status", 3'd4, 32'h2);

    // Reset mid-frame discards everything
    target = frameCount;
    applyStimulus(3'd0, 32'h5A);
    applyStimulus(3'd0, 32'h6B);
    applyStimulus(3'd0, 32'h7C);
    repeat (12) @(negedge clock);
    nreset = 1'b0;
    #1;
    checkOutput("abort_txd", 32'(txd), 32'd1);
    checkOutput("abort_irq", 32'(irq_empty), 32'd1);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    checkReg("abort_status", 3'd4, 32'h2);
    repeat (3 * FRAME) @(negedge clock);
    checkOutput("abort_frames", 32'(frameCount), 32'(target));
    checkOutput("abort_idle_txd", 32'(txd), 32'd1);

    // Unmapped offsets and upper data bits
    checkReg("read_off0", 3'd0, 32'h0);
    checkReg("read_off2", 3'd2, 32'h0);
    applyStimulus(3'd2, 32'hFF);
    checkReg("off2_write_status", 3'd4, 32'h2);
    checkOutput("off2_write_irq", 32'(irq_empty), 32'd1);
    target = frameCount + 1;
    expQ.push_back(8'h3C);
    applyStimulus(3'd0, 32'hFFFF_FF3C);
    checkReg("read_off0_busy", 3'd0, 32'h0);
    waitFrames(target);

    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
